// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package addsub_pkg;

  // Operation select encoding on the mode input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand the saturation helpers can describe.
  localparam int SAT_W_MAX = 128;

  // Most positive signed value of a w-bit word (0111..1), zero-extended to SAT_W_MAX.
  function automatic logic [SAT_W_MAX-1:0] sat_max(input int w);
    logic [SAT_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (i < w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative signed value of a w-bit word (1000..0), zero-extended to SAT_W_MAX.
  function automatic logic [SAT_W_MAX-1:0] sat_min(input int w);
    logic [SAT_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (i == w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// N-bit carry-lookahead slice: generate/propagate sum of a, b and cin.
// Latency: combinational.
// Backpressure: none (pure logic).
module cla_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from g/p terms and cin, not rippled.
  always_comb begin : lookahead
    logic acc;
    logic pp;
    acc  = 1'b0;
    pp   = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc      = acc | (pp & cin);
      c[i + 1] = acc;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/addsub_pipe_n.sv
// Pipelined two's-complement add/sub, one CHUNK-bit CLA slice per stage, carry registered between slices.
// Latency: WIDTH/CHUNK + 1 register levels from accept edge... accept at edge N gives out_valid after edge N+WIDTH/CHUNK.
// Backpressure: global stall, in_ready = !out_valid | out_ready; all stages hold together, outputs stable until taken.
// Build option: define ADDSUB_SAT_EN to clamp overflowing results to signed max/min instead of wrapping.
module addsub_pipe_n
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be a multiple of CHUNK; STAGES slices cover the word, the last
  // slice feeds the flag/saturation output register.
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  logic             advance;
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1 with cin acting as borrow, so cin is inverted too.
  assign sub_op  = (mode != MODE_ADD);
  assign b_eff   = b ^ {WIDTH{sub_op}};
  assign cin_eff = cin ^ sub_op;

  // Per-stage state: operands travel with the op, s_q accumulates finished chunks.
  logic             vld_q [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic             vld_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic [CHUNK-1:0] sum_chunk;
      logic             c_out;

      if (k == 0) begin : g_head
        assign vld_in = in_valid;
        assign c_in   = cin_eff;
        assign a_in   = a;
        assign b_in   = b_eff;
        assign s_in   = '0;
      end else begin : g_body
        assign vld_in = vld_q[k-1];
        assign c_in   = c_q[k-1];
        assign a_in   = a_q[k-1];
        assign b_in   = b_q[k-1];
        assign s_in   = s_q[k-1];
      end

      cla_chunk #(
        .N (CHUNK)
      ) u_cla (
        .a    (a_in[k*CHUNK +: CHUNK]),
        .b    (b_in[k*CHUNK +: CHUNK]),
        .cin  (c_in),
        .sum  (sum_chunk),
        .cout (c_out)
      );

      // Valid chain: cleared by reset, frozen by a stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q[k] <= 1'b0;
        end else if (advance) begin
          vld_q[k] <= vld_in;
        end
      end

      // Data path: lower chunks pass through, this stage fills in chunk k.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q[k]                  <= a_in;
          b_q[k]                  <= b_in;
          c_q[k]                  <= c_out;
          s_q[k]                  <= s_in;
          s_q[k][k*CHUNK +: CHUNK] <= sum_chunk;
        end
      end
    end
  endgenerate

`ifdef ADDSUB_SAT_EN
  localparam logic [SAT_W_MAX-1:0] SAT_MAX_FULL = sat_max(WIDTH);
  localparam logic [SAT_W_MAX-1:0] SAT_MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_MAX_W    = SAT_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_MIN_W    = SAT_MIN_FULL[WIDTH-1:0];
`endif

  logic             a_msb;
  logic             b_msb;
  logic             ovf_fin;
  logic [WIDTH-1:0] res_fin;

  // Signed overflow from operand and sum sign bits, then optional clamp.
  always_comb begin
    a_msb   = a_q[LAST][MSB];
    b_msb   = b_q[LAST][MSB];
    ovf_fin = (a_msb == b_msb) && (s_q[LAST][MSB] != a_msb);
    res_fin = s_q[LAST];
`ifdef ADDSUB_SAT_EN
    if (ovf_fin) begin
      res_fin = a_msb ? SAT_MIN_W : SAT_MAX_W;
    end
`endif
  end

  // Output register: loads only real results so bubbles never expose stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_q[LAST];
      if (vld_q[LAST]) begin
        result   <= res_fin;
        cout     <= c_q[LAST];
        overflow <= ovf_fin;
        zero     <= (res_fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_n.sv
// Scoreboard bench for addsub_pipe_n at WIDTH=16, CHUNK=4.
// Expected {cout, overflow, zero, result} is queued at accept and compared at output.
// Honours ADDSUB_SAT_EN the same way as the design build.
module tb_addsub_pipe_n;
  import addsub_pkg::*;

  localparam int W      = 16;
  localparam int STAGES = 4;

  typedef logic [18:0] exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  always #5 clk = ~clk;

  addsub_pipe_n #(
    .WIDTH (W),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  exp_t   sb_q[$];
  int     n_chk = 0;
  int     n_err = 0;
  int     n_out = 0;
  logic   acc;
  int     lat;
  int     idx;
  int     base;
  int     sent;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic   rm;
  logic   rc;
  logic   riv;
  logic   rordy;

  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,result} = a + b + cin or a - b - cin (cout = not borrow).
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic mv, input logic cv);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic [W-1:0] res;
    logic         ovf;
    beff = (mv == MODE_SUB) ? ~bv : bv;
    full = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, cv ^ (mv == MODE_SUB)};
    res  = full[W-1:0];
    ovf  = (av[W-1] == beff[W-1]) && (res[W-1] != av[W-1]);
`ifdef ADDSUB_SAT_EN
    if (ovf) res = av[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {full[W], ovf, (res == '0), res};
  endfunction

  // One cycle: drive at negedge, settle, score output handshake then input handshake.
  task automatic step(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic mv, input logic cv, input logic ordy, input exp_t expv);
    @(negedge clk);
    in_valid  = iv;
    a         = av;
    b         = bv;
    mode      = mv;
    cin       = cv;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", 19'(out_valid), 19'd0);
      end else begin
        chk(out_ready ? "result" : "held", {cout, overflow, zero, result}, sb_q[0]);
        if (out_ready) begin
          void'(sb_q.pop_front());
          n_out++;
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb_q.push_back(expv);
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic mv, input logic cv, input exp_t expv);
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1'b1, av, bv, mv, cv, 1'b1, expv);
    if (!acc) chk("accept_timeout", 19'(acc), 19'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sb_q.size() != 0; t++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
    chk("drain_empty", 19'(sb_q.size()), 19'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = MODE_ADD;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 19'(out_valid), 19'd0);
    chk("rst_outputs", {cout, overflow, zero, result}, 19'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 19'(in_ready), 19'd1);

    // Latency: accept edge to the edge after which out_valid is seen.
    step(1'b1, 16'h1234, 16'h0FFF, MODE_ADD, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h2233});
    lat = -1;
    for (int t = 1; t <= 12; t++) begin
      step(1'b0, '0, '0, MODE_ADD, 1'b0, 1'b1, '0);
      if (out_valid) begin
        lat = t - 1;
        break;
      end
    end
    chk("latency", 19'(lat), 19'(STAGES));

    // Directed corner vectors with hand-computed results.
    send(16'h0003, 16'h0005, MODE_SUB, 1'b0, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    send(16'h0005, 16'h0005, MODE_SUB, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
`ifdef ADDSUB_SAT_EN
    send(16'h7FFF, 16'h0001, MODE_ADD, 1'b0, {1'b0, 1'b1, 1'b0, 16'h7FFF});
    send(16'h8000, 16'h0001, MODE_SUB, 1'b0, {1'b1, 1'b1, 1'b0, 16'h8000});
`else
    send(16'h7FFF, 16'h0001, MODE_ADD, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
    send(16'h8000, 16'h0001, MODE_SUB, 1'b0, {1'b1, 1'b1, 1'b0, 16'h7FFF});
`endif
    send(16'hFFFF, 16'h0000, MODE_ADD, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});
    send(16'h0000, 16'h0000, MODE_SUB, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFF});
    drain();

    // Back-to-back 8 ops with consumer stalled in cycles 5..7.
    base = n_out;
    idx  = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx >= 8 && sb_q.size() == 0) break;
      ra = 16'h1000 + 16'(idx) * 16'h0111;
      rb = 16'h0F0F - 16'(idx);
      step(idx < 8, ra, rb, MODE_ADD, idx[0], !(c >= 5 && c <= 7), model(ra, rb, MODE_ADD, idx[0]));
      if (c >= 5 && c <= 7) chk("stall_in_ready", 19'(in_ready), 19'd0);
      if (acc) idx++;
    end
    chk("stall_count", 19'(n_out - base), 19'd8);
    drain();

    // Reset with three ops in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0101 * 16'(i + 1), 16'h0202, MODE_ADD, 1'b0, 1'b1,
           model(16'h0101 * 16'(i + 1), 16'h0202, MODE_ADD, 1'b0));
    end
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'hAAAA;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    chk("midrst_out_valid", 19'(out_valid), 19'd0);
    chk("midrst_outputs", {cout, overflow, zero, result}, 19'd0);
    chk("midrst_in_ready", 19'(in_ready), 19'd1);
    for (int t = 0; t < 8; t++) begin
      step(1'b0, '0, '0, MODE_ADD, 1'b0, 1'b1, '0);
      chk("post_rst_quiet", 19'(out_valid), 19'd0);
    end

    // Random traffic with random gaps and consumer stalls, boundary operands mixed in.
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      riv   = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        2:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'h8000;
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      rm = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      step(riv, ra, rb, rm, rc, rordy, model(ra, rb, rm, rc));
      if (acc) sent++;
    end
    chk("random_sent", 19'(sent), 19'd10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
